// File: rtl/ca_frame_sequencer.sv
// Single-clock timing and rule controller for the 1-D cellular-automaton VGA renderer.
// Derives cell strobes, row-phase flags and per-band rule/colour from the hvsync counters.
module ca_frame_sequencer #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned GRID_W   = 100,
  parameter int unsigned LOG_CELL = 2,
  parameter int unsigned BAND_LOG = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       cfg_we,
  input  logic [2:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       reseed,
  output logic       cell_en,
  output logic [7:0] cell_x,
  output logic       gen_row,
  output logic       seed_row,
  output logic       carry_load,
  output logic       carry_store,
  output logic [7:0] rule,
  output logic [5:0] rule_color,
  output logic [2:0] band
);

  localparam int unsigned CELL     = 1 << LOG_CELL;
  localparam int unsigned PAD_LEFT = (H_ACTIVE - (GRID_W << LOG_CELL)) / 2;
  localparam int unsigned OFS_W    = 3 + BAND_LOG;
  localparam logic [7:0] RULE_INIT [8] = '{8'd30, 8'd110, 8'd22, 8'd60,
                                           8'd118, 8'd161, 8'd90, 8'd146};

  // ST_SEED_ARMED is the post-reset SEED state: the next frame start emits the seed frame.
  typedef enum logic [1:0] {ST_SEED_ARMED, ST_SEED, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [OFS_W-1:0] offset_q, offset_d;
  logic             pending_q, pending_d;
  logic [7:0]       table_q [8];

  logic       frame_start;
  logic       reseed_req;
  logic [9:0] x, cx, ca_row;
  logic       in_grid;
  logic [OFS_W-1:0] band_sum;

  logic       cell_en_d, gen_row_d, seed_row_d, carry_load_d, carry_store_d, latch_d;
  logic [7:0] cell_x_d;
  logic [2:0] band_d;
  logic [5:0] color_d;

  assign frame_start = (hpos == '0) && (vpos == '0);
  assign reseed_req  = pending_q | reseed;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_SEED_ARMED;
      offset_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      offset_q  <= offset_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    pending_d = reseed_req;
    if (frame_start) begin
      pending_d = 1'b0;
      if (reseed_req) begin
        state_d  = ST_SEED;
        offset_d = '0;
      end else begin
        unique case (state_q)
          ST_SEED_ARMED: state_d = ST_SEED;
          ST_SEED:       state_d = ST_RUN;
          ST_RUN:        offset_d = offset_q + 1'b1;
          default:       state_d = ST_SEED;
        endcase
      end
    end
  end

  // Flags for line 0 follow the state entered at this frame start, hence state_d/offset_d.
  always_comb begin
    x         = hpos - 10'(PAD_LEFT);
    cx        = x >> LOG_CELL;
    in_grid   = (cx < 10'(GRID_W)) && display_on;
    cell_en_d = in_grid && (x[LOG_CELL-1:0] == LOG_CELL'(CELL - 1));
    cell_x_d  = cell_en_d ? cx[7:0] : cell_x;

    gen_row_d     = (vpos[LOG_CELL-1:0] == '0);
    seed_row_d    = (vpos == '0) && (state_d == ST_SEED);
    carry_load_d  = (vpos == '0) && (state_d == ST_RUN);
    carry_store_d = (vpos == 10'(CELL));

    ca_row   = vpos >> LOG_CELL;
    band_sum = OFS_W'(ca_row + 10'(offset_d));
    band_d   = band_sum[OFS_W-1 -: 3];
    color_d  = {band_d[0], 2'b11, band_d[1], band_d[2], 1'b1};
    latch_d  = (hpos == '0) && (vpos < 10'(V_ACTIVE)) && gen_row_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cell_en     <= 1'b0;
      cell_x      <= '0;
      gen_row     <= 1'b0;
      seed_row    <= 1'b0;
      carry_load  <= 1'b0;
      carry_store <= 1'b0;
      rule        <= '0;
      rule_color  <= '0;
      band        <= '0;
      for (int unsigned i = 0; i < 8; i++) table_q[i] <= RULE_INIT[i];
    end else begin
      cell_en     <= cell_en_d;
      cell_x      <= cell_x_d;
      gen_row     <= gen_row_d;
      seed_row    <= seed_row_d;
      carry_load  <= carry_load_d;
      carry_store <= carry_store_d;
      if (latch_d) begin
        band       <= band_d;
        rule       <= table_q[band_d];
        rule_color <= color_d;
      end
      if (cfg_we) table_q[cfg_addr] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_ca_frame_sequencer.sv
// Randomized/directed bench for ca_frame_sequencer against a frame-count based reference model.
module tb_ca_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] hpos, vpos;
  logic       display_on, cfg_we, reseed;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       cell_en, gen_row, seed_row, carry_load, carry_store;
  logic [7:0] cell_x, rule;
  logic [5:0] rule_color;
  logic [2:0] band;

  always #5 clk = ~clk;

  ca_frame_sequencer #(.H_ACTIVE(640), .V_ACTIVE(480), .GRID_W(100),
                       .LOG_CELL(2), .BAND_LOG(6)) dut (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .reseed(reseed),
    .cell_en(cell_en), .cell_x(cell_x), .gen_row(gen_row), .seed_row(seed_row),
    .carry_load(carry_load), .carry_store(carry_store), .rule(rule),
    .rule_color(rule_color), .band(band)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: fss = frames since last seed frame (-1 before the first frame start).
  int         fss;
  bit         pend;
  logic [7:0] tbl [8];
  logic       e_cen, e_gen, e_seed, e_cl, e_cs;
  logic [7:0] e_cx, e_rule;
  logic [5:0] e_col;
  logic [2:0] e_band;
  bit         cfg_flag, rs_flag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fss  = -1;
    pend = 0;
    tbl  = '{8'd30, 8'd110, 8'd22, 8'd60, 8'd118, 8'd161, 8'd90, 8'd146};
    {e_cen, e_gen, e_seed, e_cl, e_cs} = '0;
    e_cx = '0; e_rule = '0; e_col = '0; e_band = '0;
  endtask

  task automatic step(input int h, input int v, input logic de, input logic we,
                      input logic [2:0] a, input logic [7:0] d, input logic rs,
                      input logic r);
    int xi, off;
    logic [2:0] b;
    bit req;
    hpos = 10'(h); vpos = 10'(v); display_on = de;
    cfg_we = we; cfg_addr = a; cfg_data = d; reseed = rs; rst_n = r;
    if (!r) model_reset();
    else begin
      req = pend || rs;
      if (h == 0 && v == 0) begin
        fss  = (fss < 0 || req) ? 0 : fss + 1;
        pend = 0;
      end else pend = req;
      e_seed = (v == 0) && (fss == 0);
      e_cl   = (v == 0) && (fss >= 1);
      e_cs   = (v == 4);
      e_gen  = (v % 4 == 0);
      xi     = (h - 120 + 1024) % 1024;
      e_cen  = de && xi < 400 && (xi % 4 == 3);
      if (e_cen) e_cx = 8'(xi / 4);
      if (h == 0 && v < 480 && v % 4 == 0) begin
        off    = (fss >= 1) ? (fss - 1) % 512 : 0;
        b      = 3'(((v / 4 + off) / 64) % 8);
        e_band = b;
        e_rule = tbl[b];
        e_col  = {b[0], 1'b1, 1'b1, b[1], b[2], 1'b1};
      end
      if (we) tbl[a] = d;
    end
    @(posedge clk);
    #1;
    chk("cell_en", cell_en, e_cen);
    chk("cell_x", cell_x, e_cx);
    chk("gen_row", gen_row, e_gen);
    chk("seed_row", seed_row, e_seed);
    chk("carry_load", carry_load, e_cl);
    chk("carry_store", carry_store, e_cs);
    chk("rule", rule, e_rule);
    chk("rule_color", rule_color, e_col);
    chk("band", band, e_band);
  endtask

  task automatic rstep(input int h, input int v, input int rs_prob, input bit rand_de);
    logic de;
    de = rand_de ? 1'($urandom_range(0, 1)) : (h < 640 && v < 480);
    step(h, v, de, ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
         8'($urandom_range(0, 255)),
         (rs_prob > 0) && ($urandom_range(0, rs_prob - 1) == 0), 1'b1);
  endtask

  task automatic sweep(input int v, input bit force_off);
    int cnt, first;
    bit vis;
    cnt = 0; first = -1;
    vis = !force_off && v < 480;
    for (int h = 0; h < 800; h++) begin
      step(h, v, vis && h < 640, cfg_flag && v == 260 && h == 5, 3'd1, 8'd90,
           rs_flag && v == 300 && h == 7, 1'b1);
      if (cell_en) begin
        cnt++;
        if (first < 0) first = h;
      end
    end
    chk("cen_count", cnt, vis ? 100 : 0);
    if (vis) chk("cen_first_h", first, 123);
  endtask

  task automatic dframe();
    for (int v = 0; v < 525; v++) begin
      if (v == 0 || v == 4 || v == 260 || v == 300 || v == 500) sweep(v, 1'b0);
      else if (v == 8) sweep(v, 1'b1);
      else begin
        step(0, v, v < 480, 1'b0, 3'd0, 8'd0, 1'b0, 1'b1);
        step($urandom_range(1, 799), v, v < 480, 1'b0, 3'd0, 8'd0, 1'b0, 1'b1);
      end
    end
  endtask

  task automatic qframe(input int rs_prob, input bit rand_de);
    int v;
    rstep(0, 0, rs_prob, rand_de);
    rstep($urandom_range(1, 799), 0, rs_prob, rand_de);
    repeat (3) begin
      v = $urandom_range(1, 524);
      rstep(0, v, rs_prob, rand_de);
      rstep($urandom_range(1, 799), v, rs_prob, rand_de);
    end
  endtask

  initial begin
    cfg_flag = 0; rs_flag = 0;
    repeat (3) step(0, 0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
    for (int f = 0; f < 6; f++) begin
      cfg_flag = (f == 2);
      rs_flag  = (f == 3);
      dframe();
    end
    cfg_flag = 0; rs_flag = 0;
    // 515 consecutive run frames push the scroll offset through its wrap.
    repeat (515) qframe(0, 1'b0);
    for (int v = 100; v < 104; v++) step(0, v, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 1'b1);
    repeat (2) step(3, 105, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1, 1'b0);
    for (int v = 106; v < 110; v++) step(0, v, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 1'b1);
    repeat (40) qframe(40, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
